sink_id_pool: RTL
=================

# sink_id_pool

Parametrised sink-ID allocator for the TIDC L2 adapter. It tracks a pool of NUM_IDS transaction IDs in a bitmap and always offers the next free ID over a valid/ready handshake, searching round-robin from the last grant. It accepts one release per cycle and keeps a live occupancy count. Optional checking flags double-free and out-of-range releases. It sits between the L2 adapter's D-channel Grant issue path, which allocates, and its E-channel GrantAck sink, which releases.

## Interface
- ID_W, 4: width of an ID.
- NUM_IDS, 16: pool size. Legal range 2..2^ID_W; need not be a power of two.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- alloc_valid  out  1  a free ID is offered.
- alloc_ready  in  1  consumer takes the offered ID this cycle.
- alloc_id  out  ID_W  offered ID; valid only when alloc_valid=1.
- free_valid  in  1  release request.
- free_id  in  ID_W  ID to release.
- in_use_cnt  out  ID_W+1  number of allocated IDs.
- full  out  1  in_use_cnt == NUM_IDS.
- empty  out  1  in_use_cnt == 0.
- err_double_free  out  1  one-cycle pulse: released ID was not allocated.
- err_range  out  1  one-cycle pulse: free_id >= NUM_IDS.

## Operation
- State consists of:
  - bitmap in_use[NUM_IDS] (1 = allocated);
  - search pointer ptr (ID_W bits, range 0..NUM_IDS-1);
  - counter cnt;
  - two error flops.
- Offer:
  - alloc_id is the first index i with in_use[i]=0, scanning ptr, ptr+1, … and wrapping from NUM_IDS-1 to 0.
  - alloc_valid = (any bit clear) & ~rst.
  - Both are combinational from registered state; free_valid/free_id have no combinational path to them.
- Allocation fires when alloc_valid & alloc_ready. On that edge, in_use[alloc_id] is set and ptr becomes alloc_id+1, or 0 if alloc_id = NUM_IDS-1.
- A valid release (in range and allocated) clears in_use[free_id] on the edge.
- Simultaneous events:
  - Allocation and release are processed together on the same edge.
  - A release is never bypassed into the current offer. When the pool is full and a release occurs, alloc_valid rises in the next cycle.
  - Releasing the ID currently offered is a double-free, because that ID is free by definition.
- cnt next = cnt + fire − valid_release, giving a net 0 when both occur.
  - cnt never exceeds NUM_IDS and never underflows, because invalid releases are not counted.
- full and empty are decoded from cnt.
- alloc_ready while alloc_valid=0 has no effect.

## Timing
- Reset values:
  - in_use all 0; ptr 0; cnt 0.
  - err_double_free = 0, err_range = 0.
  - alloc_valid = 0 while rst is high.
  - alloc_id = 0, full = 0, empty = 1.
- After reset:
  - First cycle after rst deasserts: alloc_valid = 1, alloc_id = 0.
  - Allocation latency is 0 cycles: the ID is valid in the handshake cycle.
  - Back-to-back allocations, one per cycle, are sustained until the pool is full.
- Release-to-reuse latency is 1 cycle.
- Error pulses are registered and assert in the cycle after the offending free_valid.
- rst asserted mid-operation drops every ID immediately (asynchronously). IDs outstanding at that point are forgotten.

## Configuration
- SINK_ID_POOL_ERR_CHECK_EN defined:
  - An invalid release is ignored: bitmap and cnt are unchanged.
  - The matching error pulse is raised.
- Macro not defined:
  - err_double_free and err_range are tied to 0.
  - An in-range release clears the bit unconditionally.
  - cnt decrements only if the bit was set.
  - An out-of-range release is silently ignored.

## Structure
- Shared package tidc_pkg holds:
  - SINK_ID_W (default 4);
  - SINK_NUM_IDS;
  - the sink_id_t typedef (logic [SINK_ID_W-1:0]).
- One sub-module, rr_free_finder: a combinational rotate-from-ptr priority encoder.
  - Inputs: bitmap, ptr.
  - Outputs: found, idx.
  - It handles non-power-of-two wrap and is reused by the adapter's source-ID tracker.

## Test plan
- Fill the pool:
  - Stimulus: reset, then alloc_ready=1 for 17 cycles (NUM_IDS=16).
  - Required: IDs 0..15 granted in order; full=1 after the 16th; alloc_valid=0 in cycle 17; in_use_cnt=16.
- Release on full:
  - Stimulus: with the pool full, release ID 5.
  - Required: next cycle alloc_valid=1, alloc_id=5. Allocating it returns full=1, ptr=6.
- Round-robin order:
  - Stimulus: allocate 0..3, release 1, allocate once more.
  - Required: the grant is 4, not 1. Pointer search precedes lowest-index search.
- Simultaneous events:
  - Stimulus: allocate and release different IDs in the same cycle.
  - Required: in_use_cnt unchanged.
  - Stimulus: release the offered ID.
  - Required with SINK_ID_POOL_ERR_CHECK_EN: err_double_free pulses 1 cycle later; cnt is unchanged.
- Non-power-of-two pool:
  - Stimulus: NUM_IDS=10, ID_W=4; release ID 12; allocate past 9.
  - Required: err_range pulses for the release; the allocation pointer wraps 9→0.
- Reset mid-operation:
  - Stimulus: assert rst mid-burst with 7 IDs held.
  - Required: cnt=0 and alloc_valid=0 immediately. After deassertion, alloc_id=0.

Source files
------------

// File: rtl/tidc_pkg.sv
// Shared TIDC adapter types: default sink-ID width, pool size and the sink ID type.
package tidc_pkg;
    localparam int SINK_ID_W    = 4;
    localparam int SINK_NUM_IDS = 16;

    typedef logic [SINK_ID_W-1:0] sink_id_t;
endpackage

// File: rtl/sink_id_pool_if.sv
// Allocate/release handshake between the sink-ID pool and the L2 adapter's D/E channel paths.
interface sink_id_pool_if
    import tidc_pkg::*;
#(
    parameter int ID_W = SINK_ID_W
) ();
    logic            alloc_valid;
    logic            alloc_ready;
    logic [ID_W-1:0] alloc_id;
    logic            free_valid;
    logic [ID_W-1:0] free_id;

    // master: adapter side (takes offered IDs, returns released ones)
    modport master (
        input  alloc_valid,
        input  alloc_id,
        output alloc_ready,
        output free_valid,
        output free_id
    );

    modport slave (
        output alloc_valid,
        output alloc_id,
        input  alloc_ready,
        input  free_valid,
        input  free_id
    );
endinterface

// File: rtl/sink_id_pool_rr_free_finder.sv
// Rotate-from-ptr priority encoder: first clear bit at or after ptr, wrapping at NUM_IDS.
module rr_free_finder
    import tidc_pkg::*;
#(
    parameter int ID_W    = SINK_ID_W,
    parameter int NUM_IDS = SINK_NUM_IDS
) (
    input  logic [NUM_IDS-1:0] bitmap,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);
    always_comb begin
        int c;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        // Walk from the farthest offset down so the nearest free slot wins last.
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            c = int'(ptr) + i;
            if (c >= NUM_IDS) c = c - NUM_IDS;
            if (!bitmap[c]) begin
                found = 1'b1;
                idx   = ID_W'(c);
            end
        end
    end
endmodule

// File: rtl/sink_id_pool.sv
// Sink-ID allocator: bitmap pool with round-robin offer and one release per cycle.
// Define SINK_ID_POOL_ERR_CHECK_EN to reject and flag double-free / out-of-range releases.
module sink_id_pool
    import tidc_pkg::*;
#(
    parameter int ID_W    = SINK_ID_W,
    parameter int NUM_IDS = SINK_NUM_IDS
) (
    input  logic                clk,
    input  logic                rst,
    sink_id_pool_if.slave       bus,
    output logic [ID_W:0]       in_use_cnt,
    output logic                full,
    output logic                empty,
    output logic                err_double_free,
    output logic                err_range
);
    localparam logic [ID_W:0]   NUM_IDS_W = (ID_W + 1)'(NUM_IDS);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_IDS - 1);

    logic [NUM_IDS-1:0] in_use_q, in_use_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W:0]      cnt_q, cnt_d;
    logic               err_dbl_q, err_dbl_d;
    logic               err_rng_q, err_rng_d;

    logic               found;
    logic [ID_W-1:0]    offer_id;
    logic               alloc_valid;
    logic               fire;
    logic               in_range;
    logic               was_set;
    logic               rel;

    rr_free_finder #(
        .ID_W    (ID_W),
        .NUM_IDS (NUM_IDS)
    ) u_finder (
        .bitmap (in_use_q),
        .ptr    (ptr_q),
        .found  (found),
        .idx    (offer_id)
    );

    assign alloc_valid = found & ~rst;
    assign fire        = alloc_valid & bus.alloc_ready;

    always_comb begin
        in_range  = {1'b0, bus.free_id} < NUM_IDS_W;
        was_set   = 1'b0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (bus.free_id == ID_W'(i)) was_set = in_use_q[i];
        end
        // The offered ID is clear, so releasing it never collides with the set below.
        rel       = bus.free_valid & in_range & was_set;

        in_use_d  = in_use_q;
        ptr_d     = ptr_q;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (rel && bus.free_id == ID_W'(i)) in_use_d[i] = 1'b0;
            if (fire && offer_id == ID_W'(i))   in_use_d[i] = 1'b1;
        end
        if (fire) ptr_d = (offer_id == LAST_ID) ? '0 : offer_id + 1'b1;

        cnt_d     = cnt_q + (ID_W + 1)'(fire) - (ID_W + 1)'(rel);

`ifdef SINK_ID_POOL_ERR_CHECK_EN
        err_dbl_d = bus.free_valid & in_range & ~was_set;
        err_rng_d = bus.free_valid & ~in_range;
`else
        err_dbl_d = 1'b0;
        err_rng_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_use_q  <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            err_dbl_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            in_use_q  <= in_use_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            err_dbl_q <= err_dbl_d;
            err_rng_q <= err_rng_d;
        end
    end

    assign bus.alloc_valid   = alloc_valid;
    assign bus.alloc_id      = offer_id;
    assign in_use_cnt        = cnt_q;
    assign full              = (cnt_q == NUM_IDS_W);
    assign empty             = (cnt_q == '0);
    assign err_double_free   = err_dbl_q;
    assign err_range         = err_rng_q;
endmodule
